// File: rtl/sm3_cmprss_pkg.sv
// Shared types, constants and round helper functions for the SM3 compression core.
package sm3_cmprss_pkg;

    localparam logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [31:0] T_LO = 32'h79cc4519;
    localparam logic [31:0] T_HI = 32'h7a879d8a;

    typedef enum logic [1:0] {StIdle, StCmprs, StFold, StOut} state_e;

    // Working registers A..H; A sits in the most significant word.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } regs_t;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [31:0] ff_j(input logic [5:0] j, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] z);
        return (j < 6'd16) ? (x ^ y ^ z) : ((x & y) | (x & z) | (y & z));
    endfunction

    function automatic logic [31:0] gg_j(input logic [5:0] j, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] z);
        return (j < 6'd16) ? (x ^ y ^ z) : ((x & y) | (~x & z));
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
    endfunction

endpackage

// File: rtl/sm3_cmprss_core_mr_if.sv
// Expander-side and digest-side handshake bundle of the SM3 compression core.
// SM3_CMPRSS_IV_LOAD_EN adds the chaining-value load inputs.
interface sm3_cmprss_core_mr_if #(
    parameter int unsigned ROUNDS_PER_CYC = 1
);
    logic [32*ROUNDS_PER_CYC-1:0] expnd_inpt_wj_i;
    logic [32*ROUNDS_PER_CYC-1:0] expnd_inpt_wjj_i;
    logic                         expnd_inpt_lst_i;
    logic                         expnd_inpt_vld_i;
    logic                         expnd_inpt_rdy_o;
    logic [255:0]                 cmprss_otpt_res_o;
    logic                         cmprss_otpt_vld_o;
    logic                         cmprss_otpt_rdy_i;
`ifdef SM3_CMPRSS_IV_LOAD_EN
    logic [255:0]                 cmprss_inpt_iv_i;
    logic                         cmprss_inpt_iv_ld_i;
`endif

    modport slave (
`ifdef SM3_CMPRSS_IV_LOAD_EN
        input  cmprss_inpt_iv_i, cmprss_inpt_iv_ld_i,
`endif
        input  expnd_inpt_wj_i, expnd_inpt_wjj_i, expnd_inpt_lst_i, expnd_inpt_vld_i,
        input  cmprss_otpt_rdy_i,
        output expnd_inpt_rdy_o, cmprss_otpt_res_o, cmprss_otpt_vld_o
    );

    modport master (
`ifdef SM3_CMPRSS_IV_LOAD_EN
        output cmprss_inpt_iv_i, cmprss_inpt_iv_ld_i,
`endif
        output expnd_inpt_wj_i, expnd_inpt_wjj_i, expnd_inpt_lst_i, expnd_inpt_vld_i,
        output cmprss_otpt_rdy_i,
        input  expnd_inpt_rdy_o, cmprss_otpt_res_o, cmprss_otpt_vld_o
    );

endinterface

// File: rtl/sm3_cmprss_round.sv
// One combinational SM3 compression round.
module sm3_cmprss_round
    import sm3_cmprss_pkg::*;
(
    input  regs_t       regs,
    input  logic [5:0]  j,
    input  logic [31:0] wj,
    input  logic [31:0] wjj,
    output regs_t       regs_nxt
);

    logic [31:0] tj, a12, ss1, ss2, tt1, tt2;

    // Round function and register shuffle for round j.
    always_comb begin
        tj  = (j < 6'd16) ? T_LO : T_HI;
        a12 = rotl32(regs.a, 5'd12);
        ss1 = rotl32(a12 + regs.e + rotl32(tj, j[4:0]), 5'd7);
        ss2 = ss1 ^ a12;
        tt1 = ff_j(j, regs.a, regs.b, regs.c) + regs.d + ss2 + wjj;
        tt2 = gg_j(j, regs.e, regs.f, regs.g) + regs.h + ss1 + wj;
        regs_nxt.a = tt1;
        regs_nxt.b = regs.a;
        regs_nxt.c = rotl32(regs.b, 5'd9);
        regs_nxt.d = regs.c;
        regs_nxt.e = p0(tt2);
        regs_nxt.f = regs.e;
        regs_nxt.g = rotl32(regs.f, 5'd19);
        regs_nxt.h = regs.g;
    end

endmodule

// File: rtl/sm3_cmprss_core_mr.sv
// SM3 compression core running ROUNDS_PER_CYC rounds per accepted beat, carrying V across
// blocks. SM3_CMPRSS_IV_LOAD_EN enables loading V from cmprss_inpt_iv_i while idle.
module sm3_cmprss_core_mr
    import sm3_cmprss_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYC = 1
) (
    input logic               clk,
    input logic               rst,
    sm3_cmprss_core_mr_if.slave bus
);

    localparam int unsigned BEATS_PER_BLK = 64 / ROUNDS_PER_CYC;
    localparam logic [5:0]  J_STEP  = 6'(ROUNDS_PER_CYC);
    localparam logic [5:0]  J_FINAL = 6'(64 - ROUNDS_PER_CYC);

    if (ROUNDS_PER_CYC != 1 && ROUNDS_PER_CYC != 2 && ROUNDS_PER_CYC != 4) begin : g_bad_rpc
        $error("ROUNDS_PER_CYC must be 1, 2 or 4 (BEATS_PER_BLK %0d)", BEATS_PER_BLK);
    end

    state_e       state;
    logic [5:0]   j_q;
    regs_t        v_q, wrk_q;
    logic         lst_q, rdy_q, vld_q;
    logic [255:0] res_q;
    logic         iv_load, accept;
    regs_t        iv;
    regs_t        chain [ROUNDS_PER_CYC+1];

`ifdef SM3_CMPRSS_IV_LOAD_EN
    assign iv_load = bus.cmprss_inpt_iv_ld_i && (state == StIdle);
    assign iv      = regs_t'(bus.cmprss_inpt_iv_i);
`else
    assign iv_load = 1'b0;
    assign iv      = regs_t'(IV);
`endif

    // A load cycle hides ready so the beat on the bus is not consumed.
    assign bus.expnd_inpt_rdy_o  = rdy_q & ~iv_load;
    assign bus.cmprss_otpt_vld_o = vld_q;
    assign bus.cmprss_otpt_res_o = res_q;
    assign accept = bus.expnd_inpt_vld_i & bus.expnd_inpt_rdy_o;

    assign chain[0] = wrk_q;
    for (genvar k = 0; k < ROUNDS_PER_CYC; k++) begin : g_round
        sm3_cmprss_round u_round (
            .regs     (chain[k]),
            .j        (j_q + 6'(k)),
            .wj       (bus.expnd_inpt_wj_i[32*k +: 32]),
            .wjj      (bus.expnd_inpt_wjj_i[32*k +: 32]),
            .regs_nxt (chain[k+1])
        );
    end

    // Control FSM with registered ready/valid/result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
            j_q   <= 6'd0;
            v_q   <= regs_t'(IV);
            wrk_q <= regs_t'(IV);
            lst_q <= 1'b0;
            rdy_q <= 1'b0;
            vld_q <= 1'b0;
            res_q <= '0;
        end else begin
            unique case (state)
                StIdle, StCmprs: begin
                    rdy_q <= 1'b1;
                    if (iv_load) begin
                        v_q   <= iv;
                        wrk_q <= iv;
                    end else if (accept) begin
                        wrk_q <= chain[ROUNDS_PER_CYC];
                        if (j_q == J_FINAL) begin
                            lst_q <= bus.expnd_inpt_lst_i;
                            rdy_q <= 1'b0;
                            state <= StFold;
                        end else begin
                            j_q   <= j_q + J_STEP;
                            state <= StCmprs;
                        end
                    end
                end
                StFold: begin
                    v_q   <= regs_t'(v_q ^ wrk_q);
                    wrk_q <= regs_t'(v_q ^ wrk_q);
                    j_q   <= 6'd0;
                    if (lst_q) begin
                        res_q <= v_q ^ wrk_q;
                        vld_q <= 1'b1;
                        state <= StOut;
                    end else begin
                        rdy_q <= 1'b1;
                        state <= StCmprs;
                    end
                end
                StOut: begin
                    if (bus.cmprss_otpt_rdy_i) begin
                        vld_q <= 1'b0;
                        v_q   <= regs_t'(IV);
                        wrk_q <= regs_t'(IV);
                        rdy_q <= 1'b1;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sm3_cmprss_core_mr.sv
// Bench for sm3_cmprss_core_mr: three instances (1, 2, 4 rounds per cycle) driven in parallel
// against a whole-block SM3 reference model. SM3_CMPRSS_IV_LOAD_EN adds the IV-load test.
module tb_sm3_cmprss_core_mr;

    localparam logic [255:0] IV_M   = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [255:0] D_ABC  = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] D_ABCD = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_B1  = {16{32'h61626364}};
    localparam logic [511:0] BLK_B2  = {32'h80000000, 448'h0, 32'h00000200};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [127:0] wj_d [3];
    logic [127:0] wjj_d [3];
    logic         lst_d [3];
    logic         vld_d [3];
    logic         ordy_d [3];
    logic         rst_d [3];
    logic         rdy_m [3];
    logic         vld_m [3];
    logic [255:0] res_m [3];
`ifdef SM3_CMPRSS_IV_LOAD_EN
    logic [255:0] iv_d [3];
    logic         ivld_d [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned R = 1 << g;
        sm3_cmprss_core_mr_if #(.ROUNDS_PER_CYC(R)) bus ();
        assign bus.expnd_inpt_wj_i   = wj_d[g][32*R-1:0];
        assign bus.expnd_inpt_wjj_i  = wjj_d[g][32*R-1:0];
        assign bus.expnd_inpt_lst_i  = lst_d[g];
        assign bus.expnd_inpt_vld_i  = vld_d[g];
        assign bus.cmprss_otpt_rdy_i = ordy_d[g];
`ifdef SM3_CMPRSS_IV_LOAD_EN
        assign bus.cmprss_inpt_iv_i    = iv_d[g];
        assign bus.cmprss_inpt_iv_ld_i = ivld_d[g];
`endif
        assign rdy_m[g] = bus.expnd_inpt_rdy_o;
        assign vld_m[g] = bus.cmprss_otpt_vld_o;
        assign res_m[g] = bus.cmprss_otpt_res_o;
        sm3_cmprss_core_mr #(.ROUNDS_PER_CYC(R)) u_dut (
            .clk (clk),
            .rst (rst_d[g]),
            .bus (bus)
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        int s;
        s = n % 32;
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    // Message expansion: W_0..W_67 packed, W_i at [32*i +: 32].
    function automatic logic [2175:0] expand(input logic [511:0] blk);
        logic [31:0] w [68];
        logic [31:0] x;
        logic [2175:0] o;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 68; i++) begin
            x = w[i-16] ^ w[i-9] ^ rl(w[i-3], 15);
            w[i] = x ^ rl(x, 15) ^ rl(x, 23) ^ rl(w[i-13], 7) ^ w[i-6];
        end
        for (int i = 0; i < 68; i++) o[32*i +: 32] = w[i];
        return o;
    endfunction

    function automatic logic [255:0] cf(input logic [255:0] v, input logic [511:0] blk);
        logic [2175:0] ex;
        logic [31:0] r [8];
        logic [31:0] t, a12, ss1, ss2, f, gv, tt1, tt2, wj, wpj;
        ex = expand(blk);
        for (int i = 0; i < 8; i++) r[i] = v[255-32*i -: 32];
        for (int j = 0; j < 64; j++) begin
            wj  = ex[32*j +: 32];
            wpj = wj ^ ex[32*(j+4) +: 32];
            t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            a12 = rl(r[0], 12);
            ss1 = rl(a12 + r[4] + rl(t, j), 7);
            ss2 = ss1 ^ a12;
            f   = (j < 16) ? (r[0] ^ r[1] ^ r[2]) : ((r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]));
            gv  = (j < 16) ? (r[4] ^ r[5] ^ r[6]) : ((r[4] & r[5]) | (~r[4] & r[6]));
            tt1 = f + r[3] + ss2 + wpj;
            tt2 = gv + r[7] + ss1 + wj;
            r[3] = r[2]; r[2] = rl(r[1], 9);  r[1] = r[0]; r[0] = tt1;
            r[7] = r[6]; r[6] = rl(r[5], 19); r[5] = r[4]; r[4] = tt2 ^ rl(tt2, 9) ^ rl(tt2, 17);
        end
        return v ^ {r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7]};
    endfunction

    // ---------------- expected-digest scoreboard ----------------
    logic [255:0] exp_mem [3][8];
    int wr [3];
    int rd [3];

    task automatic expect_dig(input int g, input logic [255:0] d);
        exp_mem[g][wr[g]] = d;
        wr[g]++;
    endtask

    // Per-cycle output compare, sampled mid low phase.
    initial begin
        logic         prst [3];
        logic         pv [3];
        logic         phs [3];
        logic [255:0] pres [3];
        for (int g = 0; g < 3; g++) begin
            prst[g] = 1'b0; pv[g] = 1'b0; phs[g] = 1'b0; pres[g] = '0; rd[g] = 0;
        end
        forever begin
            @(negedge clk);
            #2;
            for (int g = 0; g < 3; g++) begin
                if (prst[g]) begin
                    checks++;
                    if (vld_m[g] !== 1'b0 || rdy_m[g] !== 1'b0 || res_m[g] !== 256'h0) begin
                        errors++;
                        $display("FAIL reset g=%0d: vld=%b rdy=%b res=%h, required 0/0/0",
                                 g, vld_m[g], rdy_m[g], res_m[g]);
                    end
                    pv[g] = 1'b0;
                end else if (vld_m[g] === 1'b1) begin
                    checks++;
                    if (rd[g] >= wr[g]) begin
                        errors++;
                        $display("FAIL unexpected_digest g=%0d: vld_o=1 res=%h, required no output",
                                 g, res_m[g]);
                    end else if (res_m[g] !== exp_mem[g][rd[g]]) begin
                        errors++;
                        $display("FAIL digest g=%0d: got %h, required %h", g, res_m[g],
                                 exp_mem[g][rd[g]]);
                    end
                    checks++;
                    if (rdy_m[g] !== 1'b0) begin
                        errors++;
                        $display("FAIL rdy_in_out g=%0d: rdy_o=%b, required 0", g, rdy_m[g]);
                    end
                    if (pv[g] && !phs[g]) begin
                        checks++;
                        if (res_m[g] !== pres[g]) begin
                            errors++;
                            $display("FAIL res_stable g=%0d: got %h, required %h", g, res_m[g],
                                     pres[g]);
                        end
                    end
                    pv[g]   = 1'b1;
                    phs[g]  = ordy_d[g];
                    pres[g] = res_m[g];
                    if (ordy_d[g] && rd[g] < wr[g]) rd[g]++;
                end else begin
                    pv[g] = 1'b0;
                end
                prst[g] = rst_d[g];
            end
        end
    end

    // ---------------- drivers (entered and left just after a falling edge) ----------------
    // lst_mode: 0 never, 1 on final beat only, 2 on every beat except the final one.
    task automatic send(input int g, input logic [511:0] blk, input int lst_mode, input bit gaps,
                        input int stop_at, output int c_first, output int c_last);
        logic [2175:0] ex;
        logic [127:0] lw, lwp;
        int r, nb, jj, n;
        bit acc;
        r = 1 << g;
        nb = 64 / r;
        ex = expand(blk);
        c_first = -1;
        c_last = -1;
        for (int b = 0; b < nb; b++) begin
            if (b == stop_at) break;
            if (gaps) begin
                n = int'($urandom_range(0, 3));
                repeat (n) begin
                    vld_d[g] = 1'b0;
                    wj_d[g]  = {4{$urandom()}};
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            lw = '0;
            lwp = '0;
            for (int k = 0; k < r; k++) begin
                jj = b * r + k;
                lw[32*k +: 32]  = ex[32*jj +: 32];
                lwp[32*k +: 32] = ex[32*jj +: 32] ^ ex[32*(jj+4) +: 32];
            end
            wj_d[g]  = lw;
            wjj_d[g] = lwp;
            vld_d[g] = 1'b1;
            lst_d[g] = (lst_mode == 1) ? (b == nb - 1) : (lst_mode == 2) ? (b != nb - 1) : 1'b0;
            acc = 1'b0;
            n = 0;
            while (!acc && n < 100) begin
                #1;
                acc = rdy_m[g];
                if (acc) begin
                    if (c_first < 0) c_first = cyc;
                    c_last = cyc;
                end
                @(posedge clk);
                @(negedge clk);
                n++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout g=%0d beat %0d: rdy_o stayed 0, required 1", g, b);
                break;
            end
        end
        vld_d[g] = 1'b0;
        lst_d[g] = 1'b0;
    endtask

    // Returns mid-cycle (falling edge + 1) with c_v = cycle vld_o was seen, or -1.
    task automatic wait_vld(input int g, output int c_v);
        int n;
        n = 0;
        c_v = -1;
        while (n < 300) begin
            #1;
            if (vld_m[g] === 1'b1) begin
                c_v = cyc;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (c_v < 0) begin
            checks++;
            errors++;
            $display("FAIL vld_timeout g=%0d: vld_o stayed 0, required 1", g);
        end
    endtask

    task automatic drain(input int g);
        int cv;
        wait_vld(g, cv);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int g);
        int c0, cl, cf2, cv, nb, dummy;
        logic [255:0] d_abc, d_abcd;
        nb = 64 >> g;
        d_abc  = cf(IV_M, BLK_ABC);
        d_abcd = cf(cf(IV_M, BLK_B1), BLK_B2);

        // Single block "abc" and its latency.
        expect_dig(g, d_abc);
        send(g, BLK_ABC, 1, 1'b0, -1, c0, cl);
        wait_vld(g, cv);
        checks++;
        if (cv - c0 != nb + 1) begin
            errors++;
            $display("FAIL latency g=%0d: %0d cycles, required %0d", g, cv - c0, nb + 1);
        end
        @(negedge clk);
        @(negedge clk);

        // Two blocks back to back: exactly one bubble between them.
        expect_dig(g, d_abcd);
        send(g, BLK_B1, 0, 1'b0, -1, dummy, cl);
        send(g, BLK_B2, 1, 1'b0, -1, cf2, dummy);
        checks++;
        if (cf2 - cl != 2) begin
            errors++;
            $display("FAIL bubble g=%0d: block gap %0d cycles, required 2", g, cf2 - cl);
        end
        drain(g);

        // Random input gaps with the digest held off for 20 cycles.
        ordy_d[g] = 1'b0;
        expect_dig(g, d_abc);
        send(g, BLK_ABC, 1, 1'b1, -1, dummy, dummy);
        wait_vld(g, cv);
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (vld_m[g] !== 1'b1) begin
            errors++;
            $display("FAIL hold_vld g=%0d: vld_o=%b after 20 stalled cycles, required 1", g,
                     vld_m[g]);
        end
        ordy_d[g] = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Abort a message mid-block with reset, then resend.
        send(g, BLK_ABC, 1, 1'b0, 30 >> g, dummy, dummy);
        rst_d[g] = 1'b1;
        @(negedge clk);
        rst_d[g] = 1'b0;
        expect_dig(g, d_abc);
        send(g, BLK_ABC, 1, 1'b0, -1, dummy, dummy);
        drain(g);

        // lst on non-final beats only: the core chains into a second block.
        expect_dig(g, cf(cf(IV_M, BLK_ABC), BLK_ABC));
        send(g, BLK_ABC, 2, 1'b0, -1, dummy, dummy);
        send(g, BLK_ABC, 1, 1'b0, -1, dummy, dummy);
        drain(g);

`ifdef SM3_CMPRSS_IV_LOAD_EN
        // Resume from the block-1 chaining value of "abcd"x16.
        iv_d[g] = cf(IV_M, BLK_B1);
        ivld_d[g] = 1'b1;
        #1;
        checks++;
        if (rdy_m[g] !== 1'b0) begin
            errors++;
            $display("FAIL iv_ld_rdy g=%0d: rdy_o=%b, required 0", g, rdy_m[g]);
        end
        @(negedge clk);
        ivld_d[g] = 1'b0;
        expect_dig(g, d_abcd);
        send(g, BLK_B2, 1, 1'b0, -1, dummy, dummy);
        drain(g);
        // V must be back at the constant IV afterwards.
        expect_dig(g, d_abc);
        send(g, BLK_ABC, 1, 1'b0, -1, dummy, dummy);
        drain(g);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int g = 0; g < 3; g++) begin
            rst_d[g] = 1'b1; vld_d[g] = 1'b0; lst_d[g] = 1'b0; ordy_d[g] = 1'b1;
            wj_d[g] = '0; wjj_d[g] = '0; wr[g] = 0;
`ifdef SM3_CMPRSS_IV_LOAD_EN
            iv_d[g] = '0; ivld_d[g] = 1'b0;
`endif
        end

        // Pin the model against published digests.
        checks++;
        if (cf(IV_M, BLK_ABC) !== D_ABC) begin
            errors++;
            $display("FAIL model_abc: got %h, required %h", cf(IV_M, BLK_ABC), D_ABC);
        end
        checks++;
        if (cf(cf(IV_M, BLK_B1), BLK_B2) !== D_ABCD) begin
            errors++;
            $display("FAIL model_abcd: got %h, required %h", cf(cf(IV_M, BLK_B1), BLK_B2), D_ABCD);
        end

        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) rst_d[g] = 1'b0;

        fork
            run(0);
            run(1);
            run(2);
        join

        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (rd[g] != wr[g]) begin
                errors++;
                $display("FAIL digest_count g=%0d: %0d digests delivered, required %0d", g, rd[g],
                         wr[g]);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
